// File: rtl/simple_system_key_pkg.sv
// simple_system_key_pkg: poller FSM states and key PIO word addresses
package simple_system_key_pkg;
  typedef enum logic [2:0] {IDLE, RD_EDGE, WT_EDGE, CLR, RD_LVL, WT_LVL, EMIT} state_t;
  localparam logic [1:0] KEY_ADDR_DATA = 2'd0;
  localparam logic [1:0] KEY_ADDR_EDGE = 2'd3;
endpackage

// File: rtl/simple_system_avm_single_xfer.sv
// simple_system_avm_single_xfer: one Avalon-MM read or write at a time with fixed read latency capture
// ports: rd/wr/address/writedata request levels held by the sequencer until ack;
//        avm_* master signals; ack = request accepted this cycle; done = one-cycle pulse with data captured
module simple_system_avm_single_xfer #(
  parameter int DATA_WIDTH = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [1:0]            address,
  input  logic [31:0]           writedata,
  output logic [1:0]            avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_waitrequest,
  output logic                  ack,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data
);
  localparam int LW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  logic          pend;
  logic [LW-1:0] lat;
  logic          unused_hi;
  assign avm_read      = rd & ~wr;
  assign avm_write     = wr;
  assign avm_address   = address;
  assign avm_writedata = wr ? writedata : '0;
  assign ack           = (avm_read | avm_write) & ~avm_waitrequest;
  assign unused_hi     = ^avm_readdata;
  // lat counts down from acceptance; readdata is sampled when it reaches zero
  always_ff @(posedge clk)
    if (reset) begin
      pend <= 1'b0;
      lat  <= '0;
      done <= 1'b0;
      data <= '0;
    end else begin
      done <= pend && lat == '0;
      pend <= (avm_read && ack) || (pend && lat != '0);
      lat  <= avm_read && ack ? LW'(READ_LATENCY - 1) : pend && lat != '0 ? lat - LW'(1) : lat;
      if (pend && lat == '0) data <= avm_readdata[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/simple_system_key_poller.sv
// simple_system_key_poller: polls the key PIO edge-capture register and emits key events on a valid/ready stream
// ports: clk, reset (sync, active-high); avm_* Avalon-MM master to the key PIO;
//        evt_valid/evt_ready/evt_edges/evt_level event stream; avm_irq only with KEY_POLLER_IRQ_EN
module simple_system_key_poller
  import simple_system_key_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int POLL_INTERVAL = 1000,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [1:0]            avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_waitrequest,
`ifdef KEY_POLLER_IRQ_EN
  input  logic                  avm_irq,
`endif
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [DATA_WIDTH-1:0] evt_edges,
  output logic [DATA_WIDTH-1:0] evt_level
);
  localparam int CW = POLL_INTERVAL > 1 ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(POLL_INTERVAL - 1);
  state_t                  state, state_n;
  logic [CW-1:0]           cnt;
  logic                    irq, ack, done;
  logic [DATA_WIDTH-1:0]   data;
`ifdef KEY_POLLER_IRQ_EN
  assign irq = avm_irq;
`else
  assign irq = 1'b0;
`endif
  assign evt_valid = state == EMIT;
  // cnt sits at RELOAD outside IDLE so every entry to IDLE starts a full interval
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      cnt       <= RELOAD;
      evt_edges <= '0;
      evt_level <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == IDLE && cnt != '0 ? cnt - CW'(1) : RELOAD;
      if (state == WT_EDGE && done) evt_edges <= data;
      if (state == WT_LVL && done) evt_level <= data;
    end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = cnt == '0 || irq ? RD_EDGE : IDLE;
      RD_EDGE: state_n = ack ? WT_EDGE : RD_EDGE;
      WT_EDGE: state_n = !done ? WT_EDGE : data != '0 ? CLR : IDLE;
      CLR:     state_n = ack ? RD_LVL : CLR;
      RD_LVL:  state_n = ack ? WT_LVL : RD_LVL;
      WT_LVL:  state_n = done ? EMIT : WT_LVL;
      EMIT:    state_n = evt_ready ? IDLE : EMIT;
      default: state_n = IDLE;
    endcase
  end
  simple_system_avm_single_xfer #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_xfer (
    .clk             (clk),
    .reset           (reset),
    .rd              (state == RD_EDGE || state == RD_LVL),
    .wr              (state == CLR),
    .address         (state == RD_EDGE || state == CLR ? KEY_ADDR_EDGE : KEY_ADDR_DATA),
    .writedata       (32'hFFFF_FFFF),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .ack             (ack),
    .done            (done),
    .data            (data)
  );
endmodule
